// File: rtl/carbon_sys_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : carbon_sys_init_seq
// Purpose  : Boot-time CSR initialisation sequencer. Keeps the core halted,
//            plays a fixed table of CSR writes through a CSR master with
//            per-step retry and timeout, then releases the core once.
// Revision : 1.0 - initial release
// ============================================================================
module carbon_sys_init_seq #(
    parameter int unsigned                  N_STEPS          = 6,
    parameter logic [N_STEPS-1:0][31:0]     STEP_ADDR        = '0,
    parameter logic [N_STEPS-1:0][31:0]     STEP_WDATA       = '0,
    parameter int unsigned                  MAX_RETRY        = 2,
    parameter int unsigned                  TIMEOUT_CYCLES   = 255,
    parameter logic                         RELEASE_ON_FAULT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        m_start,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_fault,
    output logic        halt_req,
    output logic        run_pulse,
    output logic        init_done,
    output logic        init_fault,
    output logic [7:0]  fault_step,
    output logic [7:0]  step_idx
);

    localparam logic [7:0]  c_LAST_IDX  = 8'(N_STEPS - 1);
    localparam logic [3:0]  c_MAX_RETRY = 4'(MAX_RETRY);
    localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_START   = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAIL    = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_idx;
    logic [3:0]  r_retry;
    logic [15:0] r_tmo;
    logic        r_halt;
    logic        r_done;
    logic        r_fault;
    logic [7:0]  r_fault_step;
    logic        w_step_ok;
    logic        w_step_err;
    logic        w_give_up;

    // State register; reset parks the sequencer in START with the core halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_START;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the single-cycle start strobe to the CSR master
    always_comb begin
        w_state_nxt = r_state;
        m_start     = 1'b0;
        w_step_ok   = 1'b0;
        w_step_err  = 1'b0;
        w_give_up   = 1'b0;
        case (r_state)
            ST_START: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!m_busy) begin
                    m_start     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A completion in the same cycle as the timeout wins
                if (m_done && !m_fault) begin
                    w_step_ok   = 1'b1;
                    w_state_nxt = (r_idx == c_LAST_IDX) ? ST_RELEASE : ST_ISSUE;
                end else if (m_done || (r_tmo == c_TMO_LAST)) begin
                    w_step_err = 1'b1;
                    if (r_retry < c_MAX_RETRY) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_give_up   = 1'b1;
                        w_state_nxt = RELEASE_ON_FAULT ? ST_RELEASE : ST_FAIL;
                    end
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE, ST_FAIL: begin
                w_state_nxt = r_state;
            end
            default: begin
                w_state_nxt = ST_START;
            end
        endcase
    end

    // Step index, retry/timeout counters and the sticky status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_retry      <= '0;
            r_tmo        <= '0;
            r_halt       <= 1'b1;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_step <= '0;
        end else begin
            // Held at zero while issuing so each WAIT visit starts counting from 0
            if (r_state == ST_ISSUE) begin
                r_tmo <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tmo <= r_tmo + 16'd1;
            end
            if (w_step_ok) begin
                r_retry <= '0;
                if (r_idx != c_LAST_IDX) begin
                    r_idx <= r_idx + 8'd1;
                end
            end else if (w_step_err) begin
                if (w_give_up) begin
                    r_fault      <= 1'b1;
                    r_fault_step <= r_idx;
                end else begin
                    r_retry <= r_retry + 4'd1;
                end
            end
            // Entering RELEASE is the only way halt drops, so it can never come back
            if (w_state_nxt == ST_RELEASE) begin
                r_halt <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // Table lookup for the current step's address and data
    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        for (int i = 0; i < int'(N_STEPS); i++) begin
            if (r_idx == i[7:0]) begin
                m_addr  = STEP_ADDR[i];
                m_wdata = STEP_WDATA[i];
            end
        end
    end

    assign m_wstrb    = 4'hF;
    assign run_pulse  = (r_state == ST_RELEASE);
    assign halt_req   = r_halt;
    assign init_done  = r_done;
    assign init_fault = r_fault;
    assign fault_step = r_fault_step;
    assign step_idx   = r_idx;

endmodule
`default_nettype wire
